// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready + rvalid
// port, steers byte lanes, extends load data and registers writeback results.
module mem_stage #(
  parameter int width   = 32,
  parameter int rsWidth = 5
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               read,
  input  logic               write,
  input  logic               noMEM,
  input  logic [width-1:0]   value,
  input  logic [width-1:0]   address,
  input  logic [2:0]         addressMode,
  input  logic [rsWidth-1:0] rd,
  output logic               memReq,
  output logic               memWe,
  output logic [width-1:0]   memAddr,
  output logic [width-1:0]   memWData,
  output logic [3:0]         memByteEn,
  input  logic               memReady,
  input  logic               memRValid,
  input  logic [width-1:0]   memRData,
  output logic               stallOut,
  output logic [rsWidth-1:0] rdOut,
  output logic [width-1:0]   valueOut,
  output logic               regWriteOut,
  output logic               misalignOut
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  state_t state, state_next;

  logic               memop;
  logic               access_ok;
  logic [3:0]         st_be;
  logic [width-1:0]   st_data;
  logic [width-1:0]   load_ext;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;

  logic               op_load_q;
  logic [1:0]         lane_q;
  logic [2:0]         mode_q;
  logic [rsWidth-1:0] rd_q;

  // The pass-through hint carries no information this stage needs.
  logic unused_nomem;
  assign unused_nomem = noMEM;

  assign memop = read | write;

  // Legal and naturally aligned; read wins when both flags are set.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    access_ok = 1'b0;
    case (addressMode)
      3'd0:    access_ok = 1'b1;
      3'd1:    access_ok = ~address[0];
      3'd2:    access_ok = (address[1:0] == 2'b00);
      3'd4:    access_ok = read;
      3'd5:    access_ok = read & ~address[0];
      default: access_ok = 1'b0;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = value;
    case (addressMode)
      3'd0: begin
        st_be   = 4'b0001 << address[1:0];
        st_data = {(width/8){value[7:0]}};
      end
      3'd1: begin
        st_be   = 4'b0011 << {address[1], 1'b0};
        st_data = {(width/16){value[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = memRData[{lane_q, 3'b000} +: 8];
    load_half = memRData[{lane_q[1], 4'b0000} +: 16];
    case (mode_q)
      3'd0:    load_ext = {{(width-8){load_byte[7]}}, load_byte};
      3'd4:    load_ext = {{(width-8){1'b0}}, load_byte};
      3'd1:    load_ext = {{(width-16){load_half[15]}}, load_half};
      3'd5:    load_ext = {{(width-16){1'b0}}, load_half};
      default: load_ext = memRData;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (memop && access_ok) state_next = REQ;
      REQ:     if (memReady) state_next = op_load_q ? WAIT_RD : IDLE;
      WAIT_RD: if (memRValid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A store leaves the stage on acceptance, so EX may advance in that cycle.
  always_comb begin
    memReq   = (state == REQ);
    stallOut = 1'b0;
    case (state)
      IDLE:    stallOut = memop & access_ok;
      REQ:     stallOut = ~(memReady & ~op_load_q);
      WAIT_RD: stallOut = ~memRValid;
      default: stallOut = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_load_q   <= 1'b0;
      lane_q      <= '0;
      mode_q      <= '0;
      rd_q        <= '0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWData    <= '0;
      memByteEn   <= '0;
      rdOut       <= '0;
      valueOut    <= '0;
      regWriteOut <= 1'b0;
      misalignOut <= 1'b0;
    end else begin
      regWriteOut <= 1'b0;
      misalignOut <= 1'b0;
      case (state)
        IDLE: begin
          if (!memop) begin
            rdOut       <= rd;
            valueOut    <= value;
            regWriteOut <= (rd != '0);
          end else if (access_ok) begin
            op_load_q <= read;
            lane_q    <= address[1:0];
            mode_q    <= addressMode;
            rd_q      <= rd;
            memWe     <= ~read;
            memAddr   <= {address[width-1:2], 2'b00};
            memWData  <= st_data;
            memByteEn <= read ? 4'b1111 : st_be;
          end else begin
            misalignOut <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (memRValid) begin
            rdOut       <= rd_q;
            valueOut    <= load_ext;
            regWriteOut <= (rd_q != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level model predicts each
// cycle's outputs; a compare process checks them on every falling edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        read = 1'b0, write = 1'b0, noMEM = 1'b0;
  logic [31:0] value = '0, address = '0;
  logic [2:0]  addressMode = '0;
  logic [4:0]  rd = '0;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic [3:0]  memByteEn;
  logic        memReady = 1'b0, memRValid = 1'b0;
  logic [31:0] memRData = '0;
  logic        stallOut;
  logic [4:0]  rdOut;
  logic [31:0] valueOut;
  logic        regWriteOut, misalignOut;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.width(32), .rsWidth(5)) dut (
    .clk(clk), .resetN(resetN), .read(read), .write(write), .noMEM(noMEM),
    .value(value), .address(address), .addressMode(addressMode), .rd(rd),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memByteEn(memByteEn), .memReady(memReady), .memRValid(memRValid),
    .memRData(memRData), .stallOut(stallOut), .rdOut(rdOut),
    .valueOut(valueOut), .regWriteOut(regWriteOut), .misalignOut(misalignOut)
  );

  typedef struct {
    bit          stall, req, chk_mem, chk_wd, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } cur_t;

  typedef struct {
    bit          rw, mis, chk_data;
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  typedef struct {
    cur_t c;
    wb_t  w;
  } exp_t;

  exp_t exp_q[$];
  wb_t  pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] m);
    return (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit access_ok(input bit ld, input logic [2:0] m, input logic [31:0] a);
    bit legal;
    legal = ld ? (m inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (m <= 3'd2);
    return legal && ((a % nbytes(m)) == 0);
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] a,
                                             input logic [2:0] m);
    int n;
    logic [31:0] lane, mask;
    n = nbytes(m);
    if (n == 4) return word;
    lane = word >> (8 * (a % 4));
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    lane = lane & mask;
    if (!m[2] && lane[8*n-1]) lane = lane | ~mask;
    return lane;
  endfunction

  function automatic logic [3:0] store_be(input logic [31:0] a, input logic [2:0] m);
    int n;
    n = nbytes(m);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] v, input logic [2:0] m);
    case (nbytes(m))
      1:       return 32'(v[7:0]) * 32'h0101_0101;
      2:       return 32'(v[15:0]) * 32'h0001_0001;
      default: return v;
    endcase
  endfunction

  function automatic wb_t mk_wb(input bit rw, input bit mis, input bit chk,
                                input logic [4:0] r, input logic [31:0] v);
    wb_t w;
    w.rw = rw; w.mis = mis; w.chk_data = chk; w.rd = r; w.val = v;
    return w;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stallOut", 32'(stallOut), 32'(e.c.stall));
      check("memReq", 32'(memReq), 32'(e.c.req));
      if (e.c.chk_mem) begin
        check("memWe", 32'(memWe), 32'(e.c.we));
        check("memAddr", memAddr, e.c.addr);
        check("memByteEn", 32'(memByteEn), 32'(e.c.be));
        if (e.c.chk_wd) check("memWData", memWData, e.c.wdata);
      end
      check("regWriteOut", 32'(regWriteOut), 32'(e.w.rw));
      check("misalignOut", 32'(misalignOut), 32'(e.w.mis));
      if (e.w.chk_data) begin
        check("rdOut", 32'(rdOut), 32'(e.w.rd));
        check("valueOut", valueOut, e.w.val);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input cur_t c, input wb_t nxt);
    exp_t e;
    e.c = c;
    e.w = pending;
    exp_q.push_back(e);
    pending = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    cur_t zc;
    zc = '{default: 0};
    zc.chk_mem = 1'b1;
    zc.chk_wd  = 1'b1;
    resetN = 1'b0;
    read = 1'b0; write = 1'b0; value = '0; address = '0; addressMode = '0; rd = '0;
    memReady = 1'b0; memRValid = 1'b0;
    pending = mk_wb(0, 0, 1, '0, '0);
    for (int i = 0; i < n; i++) cycle(zc, mk_wb(0, 0, 1, '0, '0));
  endtask

  // One EX instruction; abort leaves a load waiting for its response.
  task automatic run_instr(input bit rf, input bit wf, input logic [4:0] r,
                           input logic [31:0] v, input logic [31:0] a, input logic [2:0] m,
                           input int rdy, input int rvd, input logic [31:0] rdata,
                           input bit abort);
    cur_t c;
    wb_t  nxt0;
    bit   ld;
    c = '{default: 0};
    nxt0 = mk_wb(0, 0, 0, '0, '0);
    ld = rf;
    read = rf; write = wf; rd = r; value = v; address = a; addressMode = m;
    noMEM = 1'($urandom);
    memReady = 1'b0;
    memRValid = 1'($urandom);
    memRData = $urandom;
    if (!(rf || wf)) begin
      cycle(c, mk_wb(r != 0, 0, 1, r, v));
      return;
    end
    if (!access_ok(ld, m, a)) begin
      cycle(c, mk_wb(0, 1, 0, '0, '0));
      return;
    end
    c.stall = 1'b1;
    cycle(c, nxt0);
    c.req = 1'b1; c.chk_mem = 1'b1; c.we = !ld; c.addr = a & ~32'h3;
    c.be = ld ? 4'hF : store_be(a, m);
    c.chk_wd = !ld; c.wdata = store_data(v, m);
    for (int i = 0; i <= rdy; i++) begin
      memReady  = (i == rdy);
      memRValid = (i < rdy) ? 1'($urandom) : 1'b0;
      memRData  = $urandom;
      c.stall   = !(memReady && !ld);
      cycle(c, nxt0);
    end
    if (!ld) return;
    c = '{default: 0};
    for (int j = 1; j <= rvd; j++) begin
      memReady  = 1'b0;
      memRValid = (j == rvd) && !abort;
      memRData  = (j == rvd) ? rdata : $urandom;
      c.stall   = !memRValid;
      cycle(c, memRValid ? mk_wb(r != 0, 0, 1, r, load_model(rdata, a, m)) : nxt0);
    end
  endtask

  initial begin
    cur_t zc;
    pending = mk_wb(0, 0, 1, '0, '0);
    @(posedge clk);
    #1;
    reset_cycles(2);
    resetN = 1'b1;

    // Hand-computed values that pin the model.
    check("pin_lb", load_model(32'h80FF_0000, 32'h103, 3'd0), 32'hFFFF_FF80);
    check("pin_lhu", load_model(32'hBEEF_1234, 32'h202, 3'd5), 32'h0000_BEEF);
    check("pin_lw", load_model(32'hBEEF_1234, 32'h200, 3'd2), 32'hBEEF_1234);
    check("pin_sb_be", 32'(store_be(32'h41, 3'd0)), 32'h2);
    check("pin_sb_data", store_data(32'hAB, 3'd0), 32'hABAB_ABAB);
    check("pin_sw_mis", 32'(access_ok(0, 3'd2, 32'h6)), 32'h0);
    check("pin_lh_mis", 32'(access_ok(1, 3'd1, 32'h3)), 32'h0);

    // Directed cases.
    run_instr(0, 0, 5'd5, 32'h1234, 32'h0, 3'd0, 0, 1, '0, 0);
    run_instr(0, 0, 5'd0, 32'h5678, 32'h0, 3'd0, 0, 1, '0, 0);
    run_instr(1, 0, 5'd3, 32'h0, 32'h103, 3'd0, 2, 1, 32'h80FF_0000, 0);
    run_instr(1, 0, 5'd4, 32'h0, 32'h202, 3'd5, 1, 2, 32'hBEEF_1234, 0);
    run_instr(1, 0, 5'd6, 32'h0, 32'h200, 3'd2, 0, 1, 32'hBEEF_1234, 0);
    run_instr(0, 1, 5'd0, 32'hAB, 32'h41, 3'd0, 3, 1, '0, 0);
    run_instr(0, 1, 5'd0, 32'h1, 32'h6, 3'd2, 0, 1, '0, 0);
    run_instr(1, 0, 5'd9, 32'h0, 32'h3, 3'd1, 0, 1, '0, 0);
    run_instr(1, 1, 5'd8, 32'h1111, 32'h304, 3'd2, 1, 1, 32'h1357_9BDF, 0);

    // Reset during WAIT_RD, then a stale response after release.
    run_instr(1, 0, 5'd10, 32'h0, 32'h400, 3'd2, 0, 2, 32'hFFFF_FFFF, 1);
    reset_cycles(2);
    resetN = 1'b1;
    read = 1'b0; write = 1'b0; rd = '0; value = '0; address = '0; addressMode = '0;
    memRValid = 1'b1; memRData = 32'hDEAD_BEEF;
    zc = '{default: 0};
    zc.chk_mem = 1'b1;
    zc.chk_wd  = 1'b1;
    cycle(zc, mk_wb(0, 0, 1, '0, '0));
    run_instr(0, 0, 5'd7, 32'hCAFE, 32'h0, 3'd0, 0, 1, '0, 0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      int          kind;
      logic [2:0]  m;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      m = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(m) - 1);
      run_instr(kind == 1 || kind == 3, kind == 2 || kind == 3, 5'($urandom),
                $urandom, a, m, $urandom_range(0, 3), $urandom_range(1, 3), $urandom, 0);
    end

    run_instr(0, 0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 1, '0, 0);
    run_instr(0, 0, 5'd0, 32'h0, 32'h0, 3'd0, 0, 1, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
